hd_fifo: RTL and testbench
==========================

Name: hd_fifo

Overview:
- Parametrised successor to the single-stage valid/ready handshake block.
- Elastic buffer of DEPTH entries with independent valid/ready handshakes on the input (upstream) and output (downstream) sides.
- Absorbs backpressure and lets producer and consumer run decoupled in the same clock domain.
- Sits between any two stages of the datapath that exchange DATA_WIDTH-bit beats.

Parameters:
- DATA_WIDTH, 16: width of each data beat in bits.
- DEPTH, 4: number of storage entries; must be a power of 2 and >= 2.
- AW, $clog2(DEPTH): derived localparam, pointer width; not overridable.

Ports:
- clk  input  1  rising-edge clock, the block's only clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  FIFO can accept a beat this cycle.
- in_data  input  DATA_WIDTH  upstream beat.
- out_valid  output  1  FIFO presents a beat.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  DATA_WIDTH  head-of-queue beat.
- count  output  AW+1  current occupancy, 0..DEPTH.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high; asserting it clears state immediately, with no clock edge required.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, out_valid=0, in_ready=1 (high while rst is held), out_data=0. Storage array is not reset.
- Transfers:
  - push = in_valid && in_ready.
  - pop = out_valid && out_ready.
  - Both are evaluated on the rising clk edge.
- Outputs:
  - in_ready = (count != DEPTH), decoded from registered state only. It has no combinational path from out_ready, so a full FIFO does not accept a beat even when a pop occurs in the same cycle.
  - out_valid = (count != 0).
  - out_data = mem[rd_ptr] when out_valid=1, else 0.
- Push: mem[wr_ptr] <= in_data, and wr_ptr increments modulo DEPTH.
- Pop: rd_ptr increments modulo DEPTH.
- Count update:
  - push only: +1.
  - pop only: -1.
  - both, or neither: unchanged.
- Latency: a beat pushed into an empty FIFO is visible on out_valid/out_data on the following cycle (1-cycle latency). FIFO order is strict.
- Throughput: one push and one pop per cycle are sustained whenever 0 < count < DEPTH.
- Boundaries:
  - Full (count==DEPTH): in_ready=0; in_valid is ignored and the upstream holds in_data.
  - Empty (count==0): out_valid=0; out_ready is ignored.
  - Pointer wrap is silent and has no bubble.
- Stability (handshake rule): once out_valid=1, out_valid and out_data stay stable until a pop occurs. Upstream obeys the same rule for in_valid/in_data.
- Reset mid-operation: all queued beats are discarded, and outputs return to their reset values asynchronously. The first push after rst deasserts is accepted on the next edge.
- Unsupported: count never exceeds DEPTH or goes below 0; no overflow or underflow path exists.

Optional Feature:
- Macro: HD_FIFO_BYPASS_EN.
- Defined: when count==0, in_valid=1 and out_ready=1, the beat passes combinationally in the same cycle.
  - out_valid=1 and out_data=in_data.
  - The beat is consumed without being written.
  - Pointers and count are unchanged.
  - Zero-latency when idle.
  - When count==0 and out_ready=0, out_valid also follows in_valid; out_data=in_data and the beat is written normally.
  - All other cases match the default.
- Undefined: no combinational in->out path; minimum latency is 1 cycle, as above.

Test Plan:
- Reset: assert rst asynchronously between edges -> out_valid=0, count=0, in_ready=1, out_data=0 immediately.
- Single beat: push 0x0001 with out_ready=0 -> next cycle out_valid=1, out_data=0x0001, count=1. Raise out_ready -> pop; following cycle out_valid=0, count=0.
- Fill/full (DEPTH=4): out_ready=0, push 1,2,3,4 -> count=4, in_ready=0. Beat 5 is held for 3 cycles without push, count stays 4. Then out_ready=1 for one cycle -> pop 1; next cycle in_ready=1 and beat 5 is accepted.
- Simultaneous: at count=2 drive push and pop together for 5 cycles -> count stays 2, output order continuous.
- Wrap-around: stream 0x0001..0x000A with out_ready toggling 1,0,1,0 -> all 10 beats exit in order, no loss or duplication, count returns to 0.
- Bypass (HD_FIFO_BYPASS_EN): empty FIFO, in_valid=1, out_ready=1, in_data=0x00AB -> out_valid=1, out_data=0x00AB in the same cycle, count stays 0. Without the macro: out_valid=0 that cycle, 0x00AB appears the next cycle.

Source files
------------

// File: rtl/hd_fifo.sv
// hd_fifo: elastic valid/ready buffer of DEPTH entries between two datapath stages.
// Optional same-cycle bypass when idle is enabled by defining HD_FIFO_BYPASS_EN.
module hd_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wrPtr_q, wrPtr_d;
  logic [AW-1:0]         rdPtr_q, rdPtr_d;
  logic [AW:0]           count_q, count_d;
  logic                  fifoEmpty;
  logic                  pushEn;
  logic                  popEn;
  logic                  bypassEn;

  assign fifoEmpty = (count_q == '0);

  // in_ready comes from registered occupancy only, so a pop never frees a slot in the same cycle
  assign in_ready = (count_q != FULL_COUNT);
  assign count    = count_q;

`ifdef HD_FIFO_BYPASS_EN
  assign bypassEn  = fifoEmpty && in_valid && out_ready;
  assign out_valid = !fifoEmpty || in_valid;
  assign out_data  = !fifoEmpty ? mem_q[rdPtr_q] :
                     (in_valid ? in_data : '0);
`else
  assign bypassEn  = 1'b0;
  assign out_valid = !fifoEmpty;
  assign out_data  = !fifoEmpty ? mem_q[rdPtr_q] : '0;
`endif

  // Decide the transfers for this edge and the resulting pointer/occupancy values
  always_comb begin
    pushEn  = in_valid && in_ready && !bypassEn;
    popEn   = !fifoEmpty && out_ready;
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (pushEn) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (popEn) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
    case ({pushEn, popEn})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers, cleared immediately by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage array is written on push only and deliberately left out of reset
  always_ff @(posedge clk) begin
    if (pushEn) begin
      mem_q[wrPtr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_hd_fifo.sv
// tb_hd_fifo: directed stimulus for hd_fifo (DEPTH=4, DATA_WIDTH=16) with a queue model
// compared on every falling edge, plus literal expectations at key points.
module tb_hd_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [2:0]    count;

  int checks;
  int errors;

  logic [DW-1:0] model[$];
  logic [DW-1:0] dutLog[$];

  hd_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends even if stimulus stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue model: what the FIFO must hold after each edge, from the handshake rules alone
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model.delete();
    end else begin
      logic doPush, doPop, bypass;
`ifdef HD_FIFO_BYPASS_EN
      bypass = (model.size() == 0) && in_valid && out_ready;
`else
      bypass = 1'b0;
`endif
      doPush = in_valid && (model.size() != DEPTH) && !bypass;
      doPop  = out_ready && (model.size() != 0);
      if (doPop)  void'(model.pop_front());
      if (doPush) model.push_back(in_data);
    end
  end

  // Compare DUT outputs to the model and log every beat the consumer takes
  always @(negedge clk) begin
    if (!rst) begin
      logic          expValid;
      logic [DW-1:0] expData;
      expValid = (model.size() != 0);
      expData  = (model.size() != 0) ? model[0] : '0;
`ifdef HD_FIFO_BYPASS_EN
      if (model.size() == 0 && in_valid) begin
        expValid = 1'b1;
        expData  = in_data;
      end
`endif
      checkOutput("cmp_out_valid", 32'(out_valid), 32'(expValid));
      checkOutput("cmp_out_data",  32'(out_data),  32'(expData));
      checkOutput("cmp_count",     32'(count),     32'(model.size()));
      checkOutput("cmp_in_ready",  32'(in_ready),  32'(model.size() != DEPTH));
      if (out_valid && out_ready) dutLog.push_back(out_data);
    end
  end

  task automatic checkLog(input string name, input int n);
    checkOutput({name, "_len"}, 32'(dutLog.size()), 32'(n));
    for (int i = 0; i < n && i < dutLog.size(); i++) begin
      checkOutput({name, "_beat"}, 32'(dutLog[i]), 32'(i + 1));
    end
  endtask

  initial begin
    int k;
    int cyc;
    logic acc;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_count",     32'(count),     32'd0);
    checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
    checkOutput("rst_out_data",  32'(out_data),  32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Single beat
    applyStimulus(1'b1, 16'h0001, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("single_valid", 32'(out_valid), 32'd1);
    checkOutput("single_data",  32'(out_data),  32'h1);
    checkOutput("single_count", 32'(count),     32'd1);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("single_drained_valid", 32'(out_valid), 32'd0);
    checkOutput("single_drained_count", 32'(count),     32'd0);
    tick();

    // Fill to full, hold beat 5 under backpressure
    dutLog.delete();
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 16'(i), 1'b0);
      tick();
    end
    applyStimulus(1'b1, 16'h0005, 1'b0);
    checkOutput("full_count",    32'(count),    32'd4);
    checkOutput("full_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("full_hold_count", 32'(count), 32'd4);
    end
    applyStimulus(1'b1, 16'h0005, 1'b1);
    tick();
    applyStimulus(1'b1, 16'h0005, 1'b0);
    checkOutput("after_pop_in_ready", 32'(in_ready), 32'd1);
    checkOutput("after_pop_count",    32'(count),    32'd3);
    checkOutput("after_pop_head",     32'(out_data), 32'h2);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("beat5_accepted_count", 32'(count), 32'd4);

    // Drop to two entries, then push and pop together for five cycles
    applyStimulus(1'b0, 16'h0000, 1'b1);
    tick();
    tick();
    checkOutput("simul_start_count", 32'(count), 32'd2);
    for (int i = 6; i <= 10; i++) begin
      applyStimulus(1'b1, 16'(i), 1'b1);
      tick();
      checkOutput("simul_count", 32'(count), 32'd2);
    end
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("simul_head", 32'(out_data), 32'h9);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    tick();
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("simul_drained_count", 32'(count), 32'd0);
    checkLog("fill_order", 10);

    // Wrap-around stream with toggling consumer
    dutLog.delete();
    k = 1;
    cyc = 0;
    while (k <= 10 && cyc < 80) begin
      applyStimulus(1'b1, 16'(k), (cyc % 2) == 0);
      acc = in_ready;
      tick();
      if (acc) k++;
      cyc++;
    end
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("wrap_all_pushed", 32'(k), 32'd11);
    while (count != 0 && cyc < 160) begin
      applyStimulus(1'b0, 16'h0000, (cyc % 2) == 0);
      tick();
      cyc++;
    end
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("wrap_count", 32'(count), 32'd0);
    checkLog("wrap_order", 10);
    tick();

    // Idle FIFO with producer and consumer both ready
    applyStimulus(1'b1, 16'h00AB, 1'b1);
    #1;
`ifdef HD_FIFO_BYPASS_EN
    checkOutput("bypass_valid", 32'(out_valid), 32'd1);
    checkOutput("bypass_data",  32'(out_data),  32'hAB);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("bypass_count", 32'(count), 32'd0);
`else
    checkOutput("nobypass_valid", 32'(out_valid), 32'd0);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("nobypass_next_valid", 32'(out_valid), 32'd1);
    checkOutput("nobypass_next_data",  32'(out_data),  32'hAB);
    checkOutput("nobypass_next_count", 32'(count),     32'd1);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("nobypass_drained", 32'(count), 32'd0);
`endif

    // Reset in the middle of operation, between clock edges
    applyStimulus(1'b1, 16'h0011, 1'b0);
    tick();
    applyStimulus(1'b1, 16'h0022, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("pre_rst_count", 32'(count), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_count",     32'(count),     32'd0);
    checkOutput("midrst_in_ready",  32'(in_ready),  32'd1);
    checkOutput("midrst_out_data",  32'(out_data),  32'd0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    applyStimulus(1'b1, 16'h0055, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("post_rst_count", 32'(count),    32'd1);
    checkOutput("post_rst_data",  32'(out_data), 32'h55);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("final_count", 32'(count), 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
